target_reset_generator: RTL and testbench
=========================================

TARGET_RESET_GENERATOR -- requirements
Module: target_reset_generator

Interface
REQ-001 SHALL have parameter: CntWidth, 16, width of timing inputs and phase timer.
REQ-002 SHALL have port: clk_i  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_i  input  1  request to emit one Target Reset Pattern.
REQ-005 SHALL have port: t_low_i  input  CntWidth  SCL-low interval length, cycles.
REQ-006 SHALL have port: t_su_i  input  CntWidth  Sr setup (SCL high, SDA high), cycles.
REQ-007 SHALL have port: t_hd_i  input  CntWidth  Sr-to-P hold (SCL high, SDA low), cycles.
REQ-008 SHALL have port: abort_i  input  1  abort request (see Configuration).
REQ-009 SHALL have port: scl_o  output  1  SCL drive; 1 = released/high, 0 = driven low.
REQ-010 SHALL have port: sda_o  output  1  SDA drive; 1 = released/high, 0 = driven low.
REQ-011 SHALL have port: busy_o  output  1  high in every state except Idle.
REQ-012 SHALL have port: done_o  output  1  one-cycle pulse when the pattern completes.

Function
REQ-013 SHALL use states Idle, DriveLow, Toggle, SrSetup, SrHold, Stop.
REQ-014 In Idle, scl_o=1, sda_o=1 and busy_o=0; req_i seen in Idle SHALL enter DriveLow next cycle; req_i in any other state SHALL be ignored.
REQ-015 t_low_i, t_su_i and t_hd_i SHALL be latched on req_i acceptance; a latched value of 0 SHALL be treated as 1.
REQ-016 DriveLow SHALL last t_low cycles with scl_o=0, sda_o=1, then enter Toggle.
REQ-017 Toggle SHALL run 14 intervals of t_low cycles with scl_o=0; sda_o inverts on the first cycle of each interval.
REQ-018 A 4-bit transition counter SHALL count Toggle intervals 1..14; after the 14th interval (sda_o=1) the block enters SrSetup; the counter SHALL never wrap.
REQ-019 SrSetup SHALL last t_su cycles with scl_o=1, sda_o=1.
REQ-020 SrHold SHALL last t_hd cycles with scl_o=1, sda_o=0; its entry edge forms the repeated START.
REQ-021 Stop SHALL last 1 cycle with scl_o=1, sda_o=1 (the STOP) and done_o=1, then return to Idle.
REQ-022 SCL SHALL be low for exactly 15*t_low cycles; SDA SHALL never change in a cycle where scl_o changes.
REQ-023 done_o SHALL be 0 in every state except Stop.

Reset
REQ-024 While rst_i=1: state=Idle, scl_o=1, sda_o=1, busy_o=0, done_o=0, timer and counter cleared, with no done_o pulse.
REQ-025 Reset asserted mid-pattern SHALL release both lines immediately (asynchronously).

Configuration
REQ-026 Macro TARGET_RESET_GEN_ABORT_EN: when defined, abort_i=1 in DriveLow or Toggle SHALL force sda_o=1 for t_low cycles with scl_o=0, then release SCL and enter Idle, with no done_o pulse.
REQ-027 When TARGET_RESET_GEN_ABORT_EN is undefined, abort_i SHALL be ignored and the pattern SHALL always run to completion.
REQ-028 abort_i in SrSetup, SrHold or Stop SHALL be ignored in both builds.

Structure
REQ-029 The state enum and constant TRP_TRANSITIONS (14) SHALL live in controller_pkg.
REQ-030 The phase timer (load, decrement, expire flag) SHALL be a sub-module named trp_phase_timer.

Verification
REQ-031 t_low=4, t_su=3, t_hd=2, req_i pulse -> scl_o low 60 cycles, 14 sda_o toggles 4 cycles apart, done_o 65 cycles after first scl_o=0 cycle.
REQ-032 Output of REQ-031 fed into the target reset detector -> detector flags a reset in the Stop cycle.
REQ-033 t_low=0, t_su=0, t_hd=0 -> behaves as all 1; scl_o low 15 cycles; done_o 17 cycles after first scl_o=0 cycle.
REQ-034 req_i held high throughout a pattern -> exactly one pattern; a new pattern starts the cycle after Idle is re-entered.
REQ-035 rst_i asserted at the 7th toggle -> scl_o=1, sda_o=1 immediately; no done_o; a req_i after reset runs a full pattern.
REQ-036 TARGET_RESET_GEN_ABORT_EN defined, t_low=4, abort_i at the 5th toggle -> sda_o=1 for 4 cycles, then scl_o=1, Idle, no done_o; undefined -> full pattern and done_o.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared definitions for the target reset pattern generator: FSM state
// encoding, toggle count and transition counter width.
package controller_pkg;

    // Pattern phases; DriveLow is also reused for the abort hold phase.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DRIVE_LOW = 3'd1,
        ST_TOGGLE    = 3'd2,
        ST_SR_SETUP  = 3'd3,
        ST_SR_HOLD   = 3'd4,
        ST_STOP      = 3'd5
    } trp_state_e;

    // Number of SDA transitions generated while SCL is held low.
    localparam logic [3:0] TRP_TRANSITIONS = 4'd14;

    // Width of the toggle interval counter (counts 1..14, never wraps).
    localparam int TRP_TCNT_WIDTH = 4;

endpackage

// File: rtl/target_reset_generator_if.sv
// Bundle of the request/timing/line signals of target_reset_generator.
// master = requester side (drives req/timing/abort), slave = generator side.
interface target_reset_generator_if #(
    parameter int CntWidth = 16
) ();
    logic                req;
    logic [CntWidth-1:0] t_low;
    logic [CntWidth-1:0] t_su;
    logic [CntWidth-1:0] t_hd;
    logic                abort;
    logic                scl;
    logic                sda;
    logic                busy;
    logic                done;

    modport master (
        output req, t_low, t_su, t_hd, abort,
        input  scl, sda, busy, done
    );

    modport slave (
        input  req, t_low, t_su, t_hd, abort,
        output scl, sda, busy, done
    );
endinterface

// File: rtl/trp_phase_timer.sv
// Down-counting phase timer. A load of N (N >= 1) makes expire_o high on
// the N-th cycle after the load edge, i.e. the last cycle of an N-cycle phase.
module trp_phase_timer
    import controller_pkg::*;
#(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    output logic                expire_o
);

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [CntWidth-1:0] cnt_d;
    logic [CntWidth-1:0] cnt_q;

    // Next count: load wins, otherwise decrement down to zero and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CntOne);

endmodule

// File: rtl/target_reset_generator.sv
// Target Reset Pattern generator: SCL held low for 15*t_low cycles while
// SDA makes 14 transitions, then repeated START and STOP with SCL high.
// Optional feature macro: TARGET_RESET_GEN_ABORT_EN (abort during the
// SCL-low part: hold SDA high for t_low cycles, release SCL, back to Idle).
module target_reset_generator
    import controller_pkg::*;
#(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [CntWidth-1:0] t_low_i,
    input  logic [CntWidth-1:0] t_su_i,
    input  logic [CntWidth-1:0] t_hd_i,
    input  logic                abort_i,
    output logic                scl_o,
    output logic                sda_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    // A programmed interval of 0 behaves as 1.
    function automatic logic [CntWidth-1:0] sat_one(input logic [CntWidth-1:0] v);
        return (v == '0) ? CntOne : v;
    endfunction

    trp_state_e                state_d, state_q;
    logic                      scl_d, scl_q;
    logic                      sda_d, sda_q;
    logic                      busy_d, busy_q;
    logic                      done_d, done_q;
    logic                      abort_d, abort_q;
    logic [TRP_TCNT_WIDTH-1:0] tcnt_d, tcnt_q;
    logic [CntWidth-1:0]       t_low_d, t_low_q;
    logic [CntWidth-1:0]       t_su_d, t_su_q;
    logic [CntWidth-1:0]       t_hd_d, t_hd_q;

    logic                      load_s;
    logic [CntWidth-1:0]       load_val_s;
    logic                      expire_s;
    logic                      abort_req_s;

`ifdef TARGET_RESET_GEN_ABORT_EN
    assign abort_req_s = abort_i;
`else
    logic unused_abort_s;
    assign unused_abort_s = abort_i;
    assign abort_req_s    = 1'b0;
`endif

    trp_phase_timer #(
        .CntWidth (CntWidth)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .expire_o   (expire_s)
    );

    // Next-state and next-output logic; every phase change reloads the timer.
    always_comb begin
        state_d    = state_q;
        scl_d      = scl_q;
        sda_d      = sda_q;
        done_d     = 1'b0;
        abort_d    = abort_q;
        tcnt_d     = tcnt_q;
        t_low_d    = t_low_q;
        t_su_d     = t_su_q;
        t_hd_d     = t_hd_q;
        load_s     = 1'b0;
        load_val_s = t_low_q;

        case (state_q)
            ST_IDLE: begin
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                tcnt_d  = '0;
                abort_d = 1'b0;
                if (req_i) begin
                    state_d    = ST_DRIVE_LOW;
                    t_low_d    = sat_one(t_low_i);
                    t_su_d     = sat_one(t_su_i);
                    t_hd_d     = sat_one(t_hd_i);
                    load_s     = 1'b1;
                    load_val_s = sat_one(t_low_i);
                    scl_d      = 1'b0;
                    sda_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRIVE_LOW: begin
                if (abort_req_s && !abort_q) begin
                    abort_d    = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = t_low_q;
                    sda_d      = 1'b1;
                end else if (expire_s) begin
                    if (abort_q) begin
                        // Abort hold finished: release SCL, SDA already high.
                        state_d = ST_IDLE;
                        scl_d   = 1'b1;
                        sda_d   = 1'b1;
                        abort_d = 1'b0;
                        tcnt_d  = '0;
                    end else begin
                        state_d    = ST_TOGGLE;
                        tcnt_d     = 4'd1;
                        sda_d      = ~sda_q;
                        load_s     = 1'b1;
                        load_val_s = t_low_q;
                    end
                end else begin
                    state_d = ST_DRIVE_LOW;
                end
            end

            ST_TOGGLE: begin
                if (abort_req_s) begin
                    // SCL stays low; SDA goes high for a full t_low hold.
                    state_d    = ST_DRIVE_LOW;
                    abort_d    = 1'b1;
                    sda_d      = 1'b1;
                    load_s     = 1'b1;
                    load_val_s = t_low_q;
                end else if (expire_s) begin
                    if (tcnt_q == TRP_TRANSITIONS) begin
                        // Even number of flips leaves SDA high: safe to raise SCL.
                        state_d    = ST_SR_SETUP;
                        scl_d      = 1'b1;
                        sda_d      = 1'b1;
                        load_s     = 1'b1;
                        load_val_s = t_su_q;
                    end else begin
                        tcnt_d     = tcnt_q + 4'd1;
                        sda_d      = ~sda_q;
                        load_s     = 1'b1;
                        load_val_s = t_low_q;
                    end
                end else begin
                    state_d = ST_TOGGLE;
                end
            end

            ST_SR_SETUP: begin
                if (expire_s) begin
                    state_d    = ST_SR_HOLD;
                    sda_d      = 1'b0;
                    load_s     = 1'b1;
                    load_val_s = t_hd_q;
                end else begin
                    state_d = ST_SR_SETUP;
                end
            end

            ST_SR_HOLD: begin
                if (expire_s) begin
                    state_d = ST_STOP;
                    sda_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SR_HOLD;
                end
            end

            ST_STOP: begin
                state_d = ST_IDLE;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                tcnt_d  = '0;
            end

            default: begin
                state_d = ST_IDLE;
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                tcnt_d  = '0;
                abort_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // FSM state and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            tcnt_q  <= '0;
            t_low_q <= CntOne;
            t_su_q  <= CntOne;
            t_hd_q  <= CntOne;
        end else begin
            state_q <= state_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            tcnt_q  <= tcnt_d;
            t_low_q <= t_low_d;
            t_su_q  <= t_su_d;
            t_hd_q  <= t_hd_d;
        end
    end

    assign scl_o  = scl_q;
    assign sda_o  = sda_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_target_reset_generator.sv
// Self-checking bench for target_reset_generator. Expected line activity is
// produced from the pattern rules as a per-cycle waveform {scl,sda,busy,done}.
module tb_target_reset_generator;

    localparam int CW = 16;
    localparam logic [3:0] IDLE_W = 4'b1100;

    logic clk = 1'b0;
    logic rst;

    target_reset_generator_if #(.CntWidth(CW)) bus ();

    target_reset_generator #(.CntWidth(CW)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (bus.req),
        .t_low_i (bus.t_low),
        .t_su_i  (bus.t_su),
        .t_hd_i  (bus.t_hd),
        .abort_i (bus.abort),
        .scl_o   (bus.scl),
        .sda_o   (bus.sda),
        .busy_o  (bus.busy),
        .done_o  (bus.done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    logic [3:0] exp_q[$];
    wire  [3:0] obs = {bus.scl, bus.sda, bus.busy, bus.done};

    // Reference waveform of one complete pattern (zero intervals act as 1).
    task automatic build_wave(input int tl_in, input int ts_in, input int th_in);
        int tl = (tl_in == 0) ? 1 : tl_in;
        int ts = (ts_in == 0) ? 1 : ts_in;
        int th = (th_in == 0) ? 1 : th_in;
        exp_q.delete();
        repeat (tl) exp_q.push_back(4'b0110);
        for (int k = 1; k <= 14; k++)
            repeat (tl) exp_q.push_back((k % 2 == 1) ? 4'b0010 : 4'b0110);
        repeat (ts) exp_q.push_back(4'b1110);
        repeat (th) exp_q.push_back(4'b1010);
        exp_q.push_back(4'b1111);
    endtask

    // Issue a one-cycle request; returns at the sample point of pattern cycle 0.
    // Timing inputs are scrambled afterwards to exercise latching.
    task automatic start_pattern(input int tl, input int ts, input int th);
        @(negedge clk);
        bus.t_low = 16'(tl);
        bus.t_su  = 16'(ts);
        bus.t_hd  = 16'(th);
        bus.req   = 1'b1;
        @(negedge clk);
        bus.req   = 1'b0;
        bus.t_low = 16'($urandom_range(0, 9));
        bus.t_su  = 16'($urandom_range(0, 9));
        bus.t_hd  = 16'($urandom_range(0, 9));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_W) $display("FAIL reset_state cyc=%0d got=%b exp=%b", i, obs, IDLE_W);
            else passed++;
        end
        bus.req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_W) $display("FAIL post_reset_idle got=%b exp=%b", obs, IDLE_W);
        else passed++;
    endtask

    // Directed 4/3/2 pattern plus a behavioural target reset detector.
    task automatic test_basic();
        int low_cnt = 0, tog = 0, clash = 0, done_idx = -1, det_idx = -1;
        bit sr = 1'b0;
        logic pscl = 1'b1, psda = 1'b1;
        build_wave(4, 3, 2);
        exp_q.push_back(IDLE_W);
        start_pattern(4, 3, 2);
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            checks++;
            if (obs !== exp_q[idx]) $display("FAIL basic_wave idx=%0d got=%b exp=%b", idx, obs, exp_q[idx]);
            else passed++;
            if (!bus.scl) low_cnt++;
            if (bus.done && done_idx < 0) done_idx = idx;
            if (!bus.scl && !pscl && bus.sda != psda) tog++;
            if (bus.scl != pscl && bus.sda != psda) clash++;
            if (bus.scl && pscl && psda && !bus.sda && tog >= 14) sr = 1'b1;
            if (bus.scl && pscl && !psda && bus.sda && sr && det_idx < 0) det_idx = idx;
            pscl = bus.scl;
            psda = bus.sda;
            @(negedge clk);
        end
        checks++; if (low_cnt !== 60) $display("FAIL basic_scl_low got=%0d exp=60", low_cnt); else passed++;
        checks++; if (tog !== 14) $display("FAIL basic_toggles got=%0d exp=14", tog); else passed++;
        checks++; if (done_idx !== 65) $display("FAIL basic_done_at got=%0d exp=65", done_idx); else passed++;
        checks++; if (det_idx !== 65) $display("FAIL detector_at got=%0d exp=65", det_idx); else passed++;
        checks++; if (clash !== 0) $display("FAIL scl_sda_same_cycle got=%0d exp=0", clash); else passed++;
    endtask

    task automatic test_min_values();
        int low_cnt = 0, done_idx = -1;
        build_wave(0, 0, 0);
        exp_q.push_back(IDLE_W);
        start_pattern(0, 0, 0);
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            checks++;
            if (obs !== exp_q[idx]) $display("FAIL min_wave idx=%0d got=%b exp=%b", idx, obs, exp_q[idx]);
            else passed++;
            if (!bus.scl) low_cnt++;
            if (bus.done && done_idx < 0) done_idx = idx;
            @(negedge clk);
        end
        checks++; if (low_cnt !== 15) $display("FAIL min_scl_low got=%0d exp=15", low_cnt); else passed++;
        checks++; if (done_idx !== 17) $display("FAIL min_done_at got=%0d exp=17", done_idx); else passed++;
    endtask

    // Random timings; random req pulses during the pattern must be ignored.
    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int tl = $urandom_range(0, 6);
            int ts = $urandom_range(0, 5);
            int th = $urandom_range(0, 5);
            build_wave(tl, ts, th);
            exp_q.push_back(IDLE_W);
            start_pattern(tl, ts, th);
            for (int idx = 0; idx < exp_q.size(); idx++) begin
                checks++;
                if (obs !== exp_q[idx]) $display("FAIL rand_wave n=%0d idx=%0d got=%b exp=%b", n, idx, obs, exp_q[idx]);
                else passed++;
                bus.req = (idx < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
            end
            bus.req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int len;
        build_wave(2, 1, 1);
        len = exp_q.size();
        @(negedge clk);
        bus.t_low = 16'd2; bus.t_su = 16'd1; bus.t_hd = 16'd1;
        bus.req = 1'b1;
        @(negedge clk);
        for (int idx = 0; idx <= 2 * len + 2; idx++) begin
            logic [3:0] e;
            if (idx < len) e = exp_q[idx];
            else if (idx == len) e = IDLE_W;
            else if (idx < 2 * len + 1) e = exp_q[idx - len - 1];
            else e = IDLE_W;
            checks++;
            if (obs !== e) $display("FAIL b2b_wave idx=%0d got=%b exp=%b", idx, obs, e);
            else passed++;
            if (idx == len + 1) bus.req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int tl = 3;
        build_wave(tl, 2, 2);
        start_pattern(tl, 2, 2);
        for (int idx = 0; idx <= 7 * tl; idx++) begin
            checks++;
            if (obs !== exp_q[idx]) $display("FAIL rstmid_wave idx=%0d got=%b exp=%b", idx, obs, exp_q[idx]);
            else passed++;
            if (idx < 7 * tl) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== IDLE_W) $display("FAIL rstmid_async got=%b exp=%b", obs, IDLE_W);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== IDLE_W) $display("FAIL rstmid_held cyc=%0d got=%b exp=%b", i, obs, IDLE_W);
            else passed++;
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== IDLE_W) $display("FAIL rstmid_release got=%b exp=%b", obs, IDLE_W);
        else passed++;
        build_wave(tl, 2, 2);
        exp_q.push_back(IDLE_W);
        start_pattern(tl, 2, 2);
        for (int idx = 0; idx < exp_q.size(); idx++) begin
            checks++;
            if (obs !== exp_q[idx]) $display("FAIL rstmid_rerun idx=%0d got=%b exp=%b", idx, obs, exp_q[idx]);
            else passed++;
            @(negedge clk);
        end
    endtask

    // Abort in Toggle (5th toggle), in DriveLow and in SrSetup.
    task automatic test_abort();
        int tl = 4;
        int pos_list[3] = '{20, 2, 60};
        for (int p = 0; p < 3; p++) begin
            int pos = pos_list[p];
            build_wave(tl, 3, 2);
`ifdef TARGET_RESET_GEN_ABORT_EN
            if (pos < 15 * tl) begin
                while (exp_q.size() > pos + 1) void'(exp_q.pop_back());
                repeat (tl) exp_q.push_back(4'b0110);
            end
`endif
            exp_q.push_back(IDLE_W);
            exp_q.push_back(IDLE_W);
            start_pattern(tl, 3, 2);
            for (int idx = 0; idx < exp_q.size(); idx++) begin
                checks++;
                if (obs !== exp_q[idx]) $display("FAIL abort_wave pos=%0d idx=%0d got=%b exp=%b", pos, idx, obs, exp_q[idx]);
                else passed++;
                bus.abort = (idx == pos);
                @(negedge clk);
            end
            bus.abort = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 1'b0;
        bus.abort = 1'b0;
        bus.t_low = '0;
        bus.t_su = '0;
        bus.t_hd = '0;
        test_reset();
        test_basic();
        test_min_values();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
